// File: rtl/counterup16_mod_1clk_negedge_sync_resetp.sv
// Falling-edge up-counter with prescaler, modulo/one-shot terminal handling,
// parallel load and a small IDLE/RUN/DONE sequencer.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not counting; count and prescaler hold until load or start
// RUN   | counting; count advances on every prescaler tick
// DONE  | one-shot reached limit; count holds limit until load or start
module counterup16_mod_1clk_negedge_sync_resetp #(
   parameter int WIDTH = 16,
   parameter int PSW   = 4
) (
   input  logic             clock0,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] limit,
   input  logic             mode,
   input  logic [PSW-1:0]   prescale,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrapped,
   output logic             running,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [PSW-1:0]   pcnt;
   logic [PSW-1:0]   pcnt_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;
   logic             wrapped_nxt;
   logic             tick;

   // Prescaler terminal: one count-advance opportunity per (prescale+1) enabled edges.
   assign tick = enable & (state == ST_RUN) & (pcnt == prescale);

   // State and datapath registers, falling edge, synchronous reset.
   always_ff @(negedge clock0) begin
      if (reset) begin
         state   <= ST_IDLE;
         count   <= '0;
         pcnt    <= '0;
         tc      <= 1'b0;
         wrapped <= 1'b0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         pcnt    <= pcnt_nxt;
         tc      <= tc_nxt;
         wrapped <= wrapped_nxt;
         running <= (state_nxt == ST_RUN);
         done    <= (state_nxt == ST_DONE);
      end
   end

   // Next-state and datapath decode; load wins over start, start over tick.
   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      pcnt_nxt    = pcnt;
      tc_nxt      = 1'b0;
      wrapped_nxt = wrapped;

      if (load) begin
         count_nxt   = load_value;
         pcnt_nxt    = '0;
         wrapped_nxt = 1'b0;
         if (state == ST_DONE) begin
            state_nxt = ST_IDLE;
         end
      end else if (start) begin
         count_nxt   = '0;
         pcnt_nxt    = '0;
         wrapped_nxt = 1'b0;
         state_nxt   = ST_RUN;
      end else if (tick) begin
         pcnt_nxt = '0;
         if (count == limit) begin
            tc_nxt = 1'b1;
            if (mode) begin
               state_nxt = ST_DONE;
            end else begin
               count_nxt   = '0;
               wrapped_nxt = 1'b1;
            end
         end else begin
            // Natural rollover at all-ones is not a terminal event.
            count_nxt = count + WIDTH'(1);
         end
      end else if (enable && (state == ST_RUN)) begin
         pcnt_nxt = pcnt + PSW'(1);
      end
   end

endmodule

// File: tb/tb_counterup16_mod_1clk_negedge_sync_resetp.sv
// Directed scenarios followed by a randomized run, all checked against a
// behavioural model of the counter rules kept in this bench.
module tb_counterup16_mod_1clk_negedge_sync_resetp;

   logic        clock0;
   logic        reset;
   logic        enable;
   logic        start;
   logic        load;
   logic [15:0] load_value;
   logic [15:0] limit;
   logic        mode;
   logic [3:0]  prescale;
   logic [15:0] count;
   logic        tc;
   logic        wrapped;
   logic        running;
   logic        done;

   int total = 0;
   int bad   = 0;

   // Reference model: phase 0 idle, 1 counting, 2 finished.
   int m_phase;
   int m_count;
   int m_edges;
   int m_tc;
   int m_wrapped;

   counterup16_mod_1clk_negedge_sync_resetp dut (
      .clock0     (clock0),
      .reset      (reset),
      .enable     (enable),
      .start      (start),
      .load       (load),
      .load_value (load_value),
      .limit      (limit),
      .mode       (mode),
      .prescale   (prescale),
      .count      (count),
      .tc         (tc),
      .wrapped    (wrapped),
      .running    (running),
      .done       (done)
   );

   initial clock0 = 1'b1;
   always #5 clock0 = ~clock0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one falling edge using the inputs seen at that edge.
   task automatic model_edge();
      m_tc = 0;
      if (reset) begin
         m_phase = 0; m_count = 0; m_edges = 0; m_wrapped = 0;
      end else if (load) begin
         m_count = int'(load_value); m_edges = 0; m_wrapped = 0;
         if (m_phase == 2) m_phase = 0;
      end else if (start) begin
         m_count = 0; m_edges = 0; m_wrapped = 0; m_phase = 1;
      end else if (m_phase == 1 && enable) begin
         if (m_edges == int'(prescale)) begin
            m_edges = 0;
            if (m_count == int'(limit)) begin
               m_tc = 1;
               if (mode) m_phase = 2;
               else begin m_count = 0; m_wrapped = 1; end
            end else begin
               m_count = (m_count + 1) % 65536;
            end
         end else begin
            m_edges = (m_edges + 1) % 16;
         end
      end
   endtask

   task automatic step();
      @(negedge clock0);
      model_edge();
      #1;
      chk("count",   32'(count),   32'(m_count));
      chk("tc",      32'(tc),      32'(m_tc));
      chk("wrapped", 32'(wrapped), 32'(m_wrapped));
      chk("running", 32'(running), 32'(m_phase == 1));
      chk("done",    32'(done),    32'(m_phase == 2));
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; start = 1'b0; load = 1'b0;
      load_value = '0; limit = '0; mode = 1'b0; prescale = '0;
      m_phase = 0; m_count = 0; m_edges = 0; m_tc = 0; m_wrapped = 0;

      // Reset state
      step(); step();
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_running", 32'(running), 32'h0);

      // Free-run modulo 4, no prescale
      reset = 1'b0; limit = 16'd3; mode = 1'b0; prescale = 4'd0; enable = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      chk("fr_start_count", 32'(count), 32'h0);
      step(); step(); step();
      chk("fr_at_limit", 32'(count), 32'h3);
      step();
      chk("fr_wrap_count", 32'(count), 32'h0);
      chk("fr_wrap_tc", 32'(tc), 32'h1);
      chk("fr_wrap_sticky", 32'(wrapped), 32'h1);
      repeat (5) step();

      // One-shot to 5 with tick every third edge
      mode = 1'b1; limit = 16'd5; prescale = 4'd2; start = 1'b1;
      step();
      start = 1'b0;
      repeat (20) step();
      chk("os_done", 32'(done), 32'h1);
      chk("os_running", 32'(running), 32'h0);
      chk("os_hold", 32'(count), 32'h5);

      // Load near rollover while running; rollover is not terminal
      mode = 1'b0; limit = 16'd2; prescale = 4'd0; start = 1'b1;
      step();
      start = 1'b0; load = 1'b1; load_value = 16'hFFFE;
      step();
      load = 1'b0;
      chk("ld_value", 32'(count), 32'hFFFE);
      step(); step();
      chk("roll_zero", 32'(count), 32'h0);
      chk("roll_no_tc", 32'(tc), 32'h0);
      chk("roll_no_wrap", 32'(wrapped), 32'h0);
      step(); step(); step();
      chk("lim2_tc", 32'(tc), 32'h1);
      step();

      // Load and start together: load wins, state unchanged
      load = 1'b1; start = 1'b1; load_value = 16'h0010;
      step();
      load = 1'b0; start = 1'b0;
      chk("ls_count", 32'(count), 32'h10);
      chk("ls_running", 32'(running), 32'h1);
      chk("ls_wrapped", 32'(wrapped), 32'h0);

      // Reset mid-count overrides start and enable
      limit = 16'd100; start = 1'b1;
      step();
      start = 1'b0;
      repeat (7) step();
      chk("pre_rst_count", 32'(count), 32'h7);
      reset = 1'b1; start = 1'b1;
      step();
      reset = 1'b0; start = 1'b0;
      chk("mid_rst_running", 32'(running), 32'h0);
      step();
      chk("idle_hold", 32'(count), 32'h0);

      // Enable low freezes the run
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      enable = 1'b0;
      repeat (4) step();
      chk("freeze_count", 32'(count), 32'h2);
      enable = 1'b1;
      step();
      chk("resume_count", 32'(count), 32'h3);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         reset      = ($urandom % 80) == 0;
         load       = ($urandom % 25) == 0;
         start      = ($urandom % 20) == 0;
         enable     = ($urandom % 4) != 0;
         if (($urandom % 10) == 0) mode = 1'($urandom);
         if (($urandom % 12) == 0) limit = 16'($urandom % 9);
         if (($urandom % 15) == 0) prescale = 4'($urandom % 4);
         load_value = ($urandom % 2) ? 16'(16'hFFFC + ($urandom % 4)) : 16'($urandom % 12);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
